// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one external memory port between an instruction-fetch
// port and a data port, with a per-transaction busy timeout that aborts with err_o.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,

    output logic        err_o,

    output logic        ext_req_o,
    output logic        ext_we_o,
    output logic [31:0] ext_addr_o,
    output logic [31:0] ext_wdata_o,
    output logic [3:0]  ext_sel_o,
    input  logic [31:0] ext_rdata_i,
    input  logic        ext_ack_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_e;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic        last_if_q, last_if_d;
    logic [15:0] cnt_q, cnt_d;

    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [31:0] ext_addr_q, ext_addr_d;
    logic [31:0] ext_wdata_q, ext_wdata_d;
    logic [3:0]  ext_sel_q, ext_sel_d;

    logic        if_ack_q, if_ack_d;
    logic [31:0] if_data_q, if_data_d;
    logic        mem_ack_q, mem_ack_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        err_q, err_d;

    logic        if_req_m, mem_req_m;
    logic        grant_if, grant_mem;
    logic        finish;
    logic [15:0] cnt_inc;

    // A port whose ack is high this cycle may still be holding req; ignore it once.
    assign if_req_m  = if_req_i  & ~if_ack_q;
    assign mem_req_m = mem_req_i & ~mem_ack_q;
    assign cnt_inc   = cnt_q + 16'd1;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        last_if_d   = last_if_q;
        cnt_d       = cnt_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_sel_d   = ext_sel_q;
        if_ack_d    = 1'b0;
        if_data_d   = 32'h0;
        mem_ack_d   = 1'b0;
        mem_data_d  = 32'h0;
        err_d       = 1'b0;
        grant_if    = 1'b0;
        grant_mem   = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                grant_mem = mem_req_m && (!if_req_m || last_if_q);
                grant_if  = if_req_m && !grant_mem;
                if (grant_mem) begin
                    state_d     = BUSY_MEM;
                    last_if_d   = 1'b0;
                    cnt_d       = 16'h0;
                    ext_req_d   = 1'b1;
                    ext_we_d    = mem_we_i;
                    ext_addr_d  = mem_addr_i;
                    ext_wdata_d = mem_wdata_i;
                    ext_sel_d   = mem_sel_i;
                end else if (grant_if) begin
                    state_d     = BUSY_IF;
                    last_if_d   = 1'b1;
                    cnt_d       = 16'h0;
                    ext_req_d   = 1'b1;
                    ext_we_d    = 1'b0;
                    ext_addr_d  = if_addr_i;
                    ext_wdata_d = 32'h0;
                    ext_sel_d   = 4'hF;
                end
            end

            BUSY_IF, BUSY_MEM: begin
                if (ext_ack_i) begin
                    finish = 1'b1;
                    if (state_q == BUSY_IF) begin
                        if_ack_d  = 1'b1;
                        if_data_d = ext_rdata_i;
                    end else begin
                        mem_ack_d  = 1'b1;
                        mem_data_d = ext_we_q ? 32'h0 : ext_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    // Abort once the counter reaches the limit; data outputs stay 0.
                    if (cnt_inc == TIMEOUT_LIMIT) begin
                        finish = 1'b1;
                        err_d  = 1'b1;
                        if (state_q == BUSY_IF) begin
                            if_ack_d = 1'b1;
                        end else begin
                            mem_ack_d = 1'b1;
                        end
                    end
                end

                if (finish) begin
                    state_d     = IDLE;
                    ext_req_d   = 1'b0;
                    ext_we_d    = 1'b0;
                    ext_addr_d  = 32'h0;
                    ext_wdata_d = 32'h0;
                    ext_sel_d   = 4'h0;
                end
            end

            default: begin
                state_d   = IDLE;
                ext_req_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_if_q   <= 1'b1;
            cnt_q       <= 16'h0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 32'h0;
            ext_wdata_q <= 32'h0;
            ext_sel_q   <= 4'h0;
            if_ack_q    <= 1'b0;
            if_data_q   <= 32'h0;
            mem_ack_q   <= 1'b0;
            mem_data_q  <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_if_q   <= last_if_d;
            cnt_q       <= cnt_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_sel_q   <= ext_sel_d;
            if_ack_q    <= if_ack_d;
            if_data_q   <= if_data_d;
            mem_ack_q   <= mem_ack_d;
            mem_data_q  <= mem_data_d;
            err_q       <= err_d;
        end
    end

    assign ext_req_o   = ext_req_q;
    assign ext_we_o    = ext_we_q;
    assign ext_addr_o  = ext_addr_q;
    assign ext_wdata_o = ext_wdata_q;
    assign ext_sel_o   = ext_sel_q;
    assign if_ack_o    = if_ack_q;
    assign if_data_o   = if_data_q;
    assign mem_ack_o   = mem_ack_q;
    assign mem_rdata_o = mem_data_q;
    assign err_o       = err_q;

    ack_exclusive_a: assert property (@(posedge clk) disable iff (rst) !(if_ack_q && mem_ack_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of per-cycle vectors plus hand-written
// sequences for timeout, ack-on-timeout-edge and asynchronous reset mid-transaction.
module tb_mem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_sel;
        logic        ext_ack;
        logic [31:0] ext_rdata;
    } stim_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        if_ack;
        logic [31:0] if_data;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        err_o;
    logic        ext_req_o;
    logic        ext_we_o;
    logic [31:0] ext_addr_o;
    logic [31:0] ext_wdata_o;
    logic [3:0]  ext_sel_o;
    logic [31:0] ext_rdata_i;
    logic        ext_ack_i;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int N = 24;
    vec_t vecs [N];

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ack_o    (if_ack_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_sel_i   (mem_sel_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ack_o   (mem_ack_o),
        .err_o       (err_o),
        .ext_req_o   (ext_req_o),
        .ext_we_o    (ext_we_o),
        .ext_addr_o  (ext_addr_o),
        .ext_wdata_o (ext_wdata_o),
        .ext_sel_o   (ext_sel_o),
        .ext_rdata_i (ext_rdata_i),
        .ext_ack_i   (ext_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t st(input logic ifr, input logic [31:0] ia, input logic mr,
                                 input logic mwe, input logic [31:0] ma, input logic [31:0] mwd,
                                 input logic [3:0] ms, input logic ea, input logic [31:0] ed);
        stim_t s;
        s.if_req    = ifr;
        s.if_addr   = ia;
        s.mem_req   = mr;
        s.mem_we    = mwe;
        s.mem_addr  = ma;
        s.mem_wdata = mwd;
        s.mem_sel   = ms;
        s.ext_ack   = ea;
        s.ext_rdata = ed;
        return s;
    endfunction

    function automatic exp_t e_idle();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t e_busy(input logic we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] s);
        exp_t e;
        e = '0;
        e.req   = H;
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        e.sel   = s;
        return e;
    endfunction

    function automatic exp_t e_if_ack(input logic [31:0] d, input logic err);
        exp_t e;
        e = '0;
        e.if_ack  = H;
        e.if_data = d;
        e.err     = err;
        return e;
    endfunction

    function automatic exp_t e_mem_ack(input logic [31:0] d, input logic err);
        exp_t e;
        e = '0;
        e.mem_ack   = H;
        e.mem_rdata = d;
        e.err       = err;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic apply(input stim_t s);
        if_req_i    = s.if_req;
        if_addr_i   = s.if_addr;
        mem_req_i   = s.mem_req;
        mem_we_i    = s.mem_we;
        mem_addr_i  = s.mem_addr;
        mem_wdata_i = s.mem_wdata;
        mem_sel_i   = s.mem_sel;
        ext_ack_i   = s.ext_ack;
        ext_rdata_i = s.ext_rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, ".ext_req"},   32'(ext_req_o),   32'(e.req));
        check({tag, ".ext_we"},    32'(ext_we_o),    32'(e.we));
        check({tag, ".ext_addr"},  ext_addr_o,       e.addr);
        check({tag, ".ext_wdata"}, ext_wdata_o,      e.wdata);
        check({tag, ".ext_sel"},   32'(ext_sel_o),   32'(e.sel));
        check({tag, ".if_ack"},    32'(if_ack_o),    32'(e.if_ack));
        check({tag, ".if_data"},   if_data_o,        e.if_data);
        check({tag, ".mem_ack"},   32'(mem_ack_o),   32'(e.mem_ack));
        check({tag, ".mem_rdata"}, mem_rdata_o,      e.mem_rdata);
        check({tag, ".err"},       32'(err_o),       32'(e.err));
    endtask

    initial begin
        stim_t s_zero, s_both, s_rd;

        s_zero = st(L, 32'h0, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0);
        s_both = st(H, 32'h400, H, L, 32'h300, 32'h0, 4'hF, L, 32'h0);
        s_rd   = st(L, 32'h0, H, L, 32'h500, 32'h0, 4'hF, L, 32'h7777_7777);

        // Contention straight after reset: MEM write first, then IF.
        vecs[0]  = '{st(H, 32'h200, H, H, 32'h100, 32'hDEAD_BEEF, 4'h3, L, 32'h0),
                     e_busy(H, 32'h100, 32'hDEAD_BEEF, 4'h3)};
        vecs[1]  = '{st(H, 32'h200, H, H, 32'h100, 32'hDEAD_BEEF, 4'h3, H, 32'h1234_5678),
                     e_mem_ack(32'h0, L)};
        vecs[2]  = '{st(H, 32'h200, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0),
                     e_busy(L, 32'h200, 32'h0, 4'hF)};
        vecs[3]  = '{st(H, 32'h200, L, L, 32'h0, 32'h0, 4'h0, H, 32'hCAFE_F00D),
                     e_if_ack(32'hCAFE_F00D, L)};
        vecs[4]  = '{s_zero, e_idle()};
        // Single fetch with a 3-cycle memory, then a held request in its ack cycle and a stray ack.
        vecs[5]  = '{st(H, 32'h10, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0), e_busy(L, 32'h10, 32'h0, 4'hF)};
        vecs[6]  = '{st(H, 32'h10, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0), e_busy(L, 32'h10, 32'h0, 4'hF)};
        vecs[7]  = '{st(H, 32'h10, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0), e_busy(L, 32'h10, 32'h0, 4'hF)};
        vecs[8]  = '{st(H, 32'h10, L, L, 32'h0, 32'h0, 4'h0, H, 32'h0011_2233),
                     e_if_ack(32'h0011_2233, L)};
        vecs[9]  = '{st(H, 32'h10, L, L, 32'h0, 32'h0, 4'h0, H, 32'hFFFF_FFFF), e_idle()};
        vecs[10] = '{s_zero, e_idle()};
        // Both ports continuously requesting: MEM, IF, MEM, IF, MEM, IF.
        vecs[11] = '{s_both, e_busy(L, 32'h300, 32'h0, 4'hF)};
        vecs[12] = '{st(H, 32'h400, H, L, 32'h300, 32'h0, 4'hF, H, 32'hA1), e_mem_ack(32'hA1, L)};
        vecs[13] = '{s_both, e_busy(L, 32'h400, 32'h0, 4'hF)};
        vecs[14] = '{st(H, 32'h400, H, L, 32'h300, 32'h0, 4'hF, H, 32'hB2), e_if_ack(32'hB2, L)};
        vecs[15] = '{s_both, e_busy(L, 32'h300, 32'h0, 4'hF)};
        vecs[16] = '{st(H, 32'h400, H, L, 32'h300, 32'h0, 4'hF, H, 32'hC3), e_mem_ack(32'hC3, L)};
        vecs[17] = '{s_both, e_busy(L, 32'h400, 32'h0, 4'hF)};
        vecs[18] = '{st(H, 32'h400, H, L, 32'h300, 32'h0, 4'hF, H, 32'hD4), e_if_ack(32'hD4, L)};
        vecs[19] = '{s_both, e_busy(L, 32'h300, 32'h0, 4'hF)};
        vecs[20] = '{st(H, 32'h400, H, L, 32'h300, 32'h0, 4'hF, H, 32'hE5), e_mem_ack(32'hE5, L)};
        vecs[21] = '{s_both, e_busy(L, 32'h400, 32'h0, 4'hF)};
        vecs[22] = '{st(H, 32'h400, H, L, 32'h300, 32'h0, 4'hF, H, 32'hF6), e_if_ack(32'hF6, L)};
        vecs[23] = '{s_zero, e_idle()};

        rst = 1'b1;
        apply(s_zero);
        #12;
        compare("reset", e_idle());
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            apply(vecs[i].s);
            tick();
            compare($sformatf("v%0d", i), vecs[i].e);
        end

        // Timeout: memory never answers, abort after 4 busy cycles, later stray ack ignored.
        apply(s_rd);
        tick();
        compare("to_grant", e_busy(L, 32'h500, 32'h0, 4'hF));
        for (int i = 1; i <= 3; i++) begin
            tick();
            compare($sformatf("to_busy%0d", i), e_busy(L, 32'h500, 32'h0, 4'hF));
        end
        tick();
        compare("to_abort", e_mem_ack(32'h0, H));
        apply(st(L, 32'h0, L, L, 32'h0, 32'h0, 4'h0, H, 32'h1111_1111));
        tick();
        compare("to_stray", e_idle());
        apply(s_zero);
        tick();
        compare("to_quiet", e_idle());

        // Ack arriving on the very edge the timeout would fire counts as normal completion.
        apply(s_rd);
        tick();
        compare("race_grant", e_busy(L, 32'h500, 32'h0, 4'hF));
        repeat (3) tick();
        compare("race_busy", e_busy(L, 32'h500, 32'h0, 4'hF));
        apply(st(L, 32'h0, H, L, 32'h500, 32'h0, 4'hF, H, 32'h5A5A_5A5A));
        tick();
        compare("race_ack", e_mem_ack(32'h5A5A_5A5A, L));
        apply(s_zero);
        tick();
        compare("race_quiet", e_idle());

        // Reset mid-transaction clears outputs without a clock edge; pending fetch wins afterwards.
        apply(s_rd);
        tick();
        compare("rst_busy", e_busy(L, 32'h500, 32'h0, 4'hF));
        apply(st(H, 32'h600, H, L, 32'h500, 32'h0, 4'hF, L, 32'h0));
        rst = 1'b1;
        #1;
        compare("rst_async", e_idle());
        apply(st(H, 32'h600, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0));
        #1;
        rst = 1'b0;
        tick();
        compare("rst_regrant", e_busy(L, 32'h600, 32'h0, 4'hF));
        apply(st(H, 32'h600, L, L, 32'h0, 32'h0, 4'h0, H, 32'h0BAD_F00D));
        tick();
        compare("rst_ack", e_if_ack(32'h0BAD_F00D, L));
        apply(s_zero);
        tick();
        compare("rst_quiet", e_idle());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: busy cycles allowed before a transaction is aborted; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 if_req_i  input  1  instruction-fetch request; held high with stable address until if_ack_o.
REQ-005 if_addr_i  input  32  fetch byte address.
REQ-006 if_data_o  output  32  fetched word; valid only while if_ack_o=1.
REQ-007 if_ack_o  output  1  one-cycle completion pulse for fetch.
REQ-008 mem_req_i  input  1  data-port request; held high with stable fields until mem_ack_o.
REQ-009 mem_we_i  input  1  1=write, 0=read.
REQ-010 mem_addr_i  input  32  data byte address.
REQ-011 mem_wdata_i  input  32  write data.
REQ-012 mem_sel_i  input  4  byte-lane enables.
REQ-013 mem_rdata_o  output  32  read data; valid only while mem_ack_o=1.
REQ-014 mem_ack_o  output  1  one-cycle completion pulse for data port.
REQ-015 err_o  output  1  asserted with if_ack_o or mem_ack_o when the transaction timed out.
REQ-016 ext_req_o, ext_we_o (1), ext_addr_o (32), ext_wdata_o (32), ext_sel_o (4)  outputs  registered request to the shared memory.
REQ-017 ext_rdata_i  input  32; ext_ack_i  input  1  memory read data and completion strobe.

Function
REQ-018 States SHALL be IDLE, BUSY_IF, BUSY_MEM; BUSY_IF and BUSY_MEM are the only states with ext_req_o=1.
REQ-019 IDLE, only one unmasked request -> SHALL go to that requester's BUSY state at the next edge.
REQ-020 IDLE, both requesting -> SHALL grant the requester not granted last (round-robin); after reset the last-grant record SHALL be IF, so MEM wins first contention.
REQ-021 On grant, ext_addr_o/ext_we_o/ext_wdata_o/ext_sel_o SHALL be loaded from the granted port (fetch: we=0, sel=4'hF, wdata=0) and held constant until the transaction ends.
REQ-022 In BUSY, an edge with ext_ack_i=1 SHALL: return to IDLE, clear ext_req_o, pulse the granted port's ack for exactly one cycle, and register ext_rdata_i onto that port's data output (writes: data output 0).
REQ-023 Latency: request sampled at edge N -> ext_req_o high after N; ext_ack_i at edge M>N -> ack pulse in cycle after M; minimum request-to-ack 2 cycles.
REQ-024 During the cycle a port's ack_o=1, that port's req SHALL be masked in IDLE so a request being dropped is not re-granted; the other port may be granted in that cycle.
REQ-025 A 16-bit busy counter SHALL clear on grant and increment every BUSY cycle without ext_ack_i.
REQ-026 Counter reaching TIMEOUT_CYCLES SHALL abort: return to IDLE, clear ext_req_o, pulse ack_o with err_o=1 and data output 0; last-grant record updates as for normal completion.
REQ-027 ext_ack_i=1 in IDLE SHALL be ignored; ext_ack_i on the same edge the timeout fires SHALL count as normal completion (err_o=0).
REQ-028 Port outputs of the non-granted port SHALL stay 0; if_ack_o and mem_ack_o SHALL never be high in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, last-grant=IF, counter=0, and all outputs (ext_*, *_ack_o, *_data_o, err_o) to 0, including mid-transaction.
REQ-030 After rst deasserts, first grant SHALL be possible at the first rising edge with rst=0.

Verification
REQ-031 if_req_i=1, addr=0x0000_0010; memory acks 3 cycles after ext_req_o with 0x0011_2233 -> ext_addr_o=0x10, we=0, sel=F; if_ack_o one cycle, if_data_o=0x0011_2233, err_o=0.
REQ-032 if_req_i and mem_req_i rise together after reset (mem write 0xDEAD_BEEF to 0x100, sel=4'b0011) -> MEM granted first, ext_wdata_o=0xDEAD_BEEF, sel=3; after mem_ack_o, IF granted next.
REQ-033 Both ports continuously re-requesting for 6 transactions -> grants alternate MEM,IF,MEM,IF,MEM,IF; no double grant of a port from its masked ack cycle.
REQ-034 TIMEOUT_CYCLES=4, mem read, ext_ack_i never asserted -> after 4 busy cycles ext_req_o=0, mem_ack_o=1, err_o=1, mem_rdata_o=0; later stray ext_ack_i ignored.
REQ-035 rst pulsed while BUSY_MEM with ext_req_o=1 -> ext_req_o and all acks 0 asynchronously; a pending if_req_i is granted at the first edge after release.
